fir_mc_ctrl: RTL and testbench

//  Control FSM for a time-multiplexed, multi-channel FIR datapath (one shared MAC).

---
 rtl/fir_pkg.sv | 33 +++
 rtl/fir_tap_agu.sv | 91 +++++++++
 rtl/fir_mc_ctrl.sv | 150 +++++++++++++++
 tb/tb_fir_mc_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and width helpers for the multi-channel FIR controller.
package fir_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MAC,
        DRAIN,
        WRITE,
        OUT
    } state_e;

    // Index width into one channel's delay line / coefficient table.
    function automatic int addr_w(input int coeff_count);
        return $clog2(coeff_count);
    endfunction

    // Channel id width; a single channel still needs a 1-bit field.
    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    // MAC cycles per sample; folded taps process two delay entries per cycle.
    function automatic int taps(input int coeff_count, input int symmetric);
        return (symmetric != 0) ? coeff_count / 2 : coeff_count;
    endfunction

    // Width of a down-counter covering n cycles.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fir_tap_agu.sv
// Tap address generator: per-channel circular write pointers, the tap index k,
// and the delay-line read/write addresses presented to the datapath.
module fir_tap_agu
    import fir_pkg::*;
#(
    parameter  int COEFF_COUNT = 64,
    parameter  int CHANNELS    = 4,
    parameter  int SYMMETRIC   = 0,
    localparam int ADDR_W      = addr_w(COEFF_COUNT),
    localparam int CH_W        = ch_w(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc_ptr,
    input  logic                   clr_k,
    input  logic                   inc_k,
    input  logic                   addr_en,
    input  logic [CH_W-1:0]        ch,
    output logic [ADDR_W-1:0]      coeff_addr,
    output logic [CH_W+ADDR_W-1:0] samp_addr_a,
    output logic [CH_W+ADDR_W-1:0] samp_addr_b
);

    logic [ADDR_W-1:0]      wr_ptr_q [CHANNELS];
    logic [ADDR_W-1:0]      k_q, k_d;
    logic [ADDR_W-1:0]      cur_ptr;
    logic [CH_W+ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [CH_W+ADDR_W-1:0] addr_b_q, addr_b_d;

    // Only the active channel's pointer advances; wraps by truncation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                wr_ptr_q[i] <= '0;
            end
        end else if (inc_ptr) begin
            wr_ptr_q[ch] <= wr_ptr_q[ch] + ADDR_W'(1);
        end
    end

    // Tap index: cleared while idle, stepped once per MAC cycle.
    always_comb begin
        k_d = k_q;
        if (clr_k) begin
            k_d = '0;
        end else if (inc_k) begin
            k_d = k_q + ADDR_W'(1);
        end
    end

    // Tap index register.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= '0;
        end else begin
            k_q <= k_d;
        end
    end

    // Addresses follow k/pointer while LOAD/MAC drive them, otherwise the
    // last driven value is held so the bus stays quiet between samples.
    always_comb begin
        cur_ptr  = wr_ptr_q[ch];
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        if (addr_en) begin
            addr_a_d = {ch, cur_ptr - k_q};
            if (SYMMETRIC != 0) begin
                addr_b_d = {ch, cur_ptr - (ADDR_W'(COEFF_COUNT - 1) - k_q)};
            end else begin
                addr_b_d = '0;
            end
        end
    end

    // Hold registers for the delay-line addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
        end else begin
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
        end
    end

    assign coeff_addr  = k_q;
    assign samp_addr_a = addr_a_d;
    assign samp_addr_b = addr_b_d;

endmodule

// File: rtl/fir_mc_ctrl.sv
// Control FSM for a time-multiplexed multi-channel FIR: accepts a tagged
// sample, sequences load / MAC / pipeline drain / result write, and presents
// the result on a ready/valid output with backpressure.
module fir_mc_ctrl
    import fir_pkg::*;
#(
    parameter  int COEFF_COUNT = 64,
    parameter  int CHANNELS    = 4,
    parameter  int SYMMETRIC   = 0,
    parameter  int PIPE_LAT    = 2,
    localparam int ADDR_W      = addr_w(COEFF_COUNT),
    localparam int CH_W        = ch_w(CHANNELS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [CH_W-1:0]        in_ch,
    output logic                   in_ready,
    output logic                   dp_clr,
    output logic                   ld_in,
    output logic                   mac_en,
    output logic                   ld_out,
    output logic [ADDR_W-1:0]      coeff_addr,
    output logic [CH_W+ADDR_W-1:0] samp_addr_a,
    output logic [CH_W+ADDR_W-1:0] samp_addr_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CH_W-1:0]        out_ch
);

    localparam int          TAPS       = taps(COEFF_COUNT, SYMMETRIC);
    localparam int          CNT_W      = cnt_w(PIPE_LAT);
    localparam int unsigned NCH        = CHANNELS;
    localparam int unsigned DRAIN_INIT = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;
    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(TAPS - 1);

    state_e           state_q, state_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic             clr_k, inc_k, inc_ptr, addr_en;

    // Out-of-range channel ids are handshaken and silently dropped.
    assign accept = (state_q == IDLE) && in_valid && (32'(in_ch) < NCH);

    // State, latched channel and drain counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the drain counter is preloaded on the last MAC cycle.
    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ch_d    = in_ch;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = MAC;
            MAC: begin
                if (coeff_addr == K_LAST) begin
                    cnt_d   = CNT_W'(DRAIN_INIT);
                    state_d = (PIPE_LAT > 0) ? DRAIN : WRITE;
                end
            end
            DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: state_d = OUT;
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore output decode of the registered state.
    always_comb begin
        in_ready  = 1'b0;
        dp_clr    = 1'b0;
        ld_in     = 1'b0;
        mac_en    = 1'b0;
        ld_out    = 1'b0;
        out_valid = 1'b0;
        clr_k     = 1'b0;
        inc_k     = 1'b0;
        inc_ptr   = 1'b0;
        addr_en   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                clr_k    = 1'b1;
            end
            LOAD: begin
                ld_in   = 1'b1;
                dp_clr  = 1'b1;
                addr_en = 1'b1;
            end
            MAC: begin
                mac_en  = 1'b1;
                inc_k   = 1'b1;
                addr_en = 1'b1;
            end
            WRITE: begin
                ld_out  = 1'b1;
                inc_ptr = 1'b1;
            end
            OUT:     out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_ch = ch_q;

    fir_tap_agu #(
        .COEFF_COUNT (COEFF_COUNT),
        .CHANNELS    (CHANNELS),
        .SYMMETRIC   (SYMMETRIC)
    ) u_agu (
        .clk         (clk),
        .rst         (rst),
        .inc_ptr     (inc_ptr),
        .clr_k       (clr_k),
        .inc_k       (inc_k),
        .addr_en     (addr_en),
        .ch          (ch_q),
        .coeff_addr  (coeff_addr),
        .samp_addr_a (samp_addr_a),
        .samp_addr_b (samp_addr_b)
    );

endmodule

// File: tb/tb_fir_mc_ctrl.sv
// Directed bench for fir_mc_ctrl: a default-parameter instance (A) and a
// folded-tap, zero-drain, three-channel instance (B).
module tb_fir_mc_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;

    // Instance A: COEFF_COUNT=64, CHANNELS=4, SYMMETRIC=0, PIPE_LAT=2
    logic       a_in_valid, a_in_ready, a_dp_clr, a_ld_in, a_mac_en, a_ld_out;
    logic       a_out_valid, a_out_ready;
    logic [1:0] a_in_ch, a_out_ch;
    logic [5:0] a_coeff_addr;
    logic [7:0] a_samp_addr_a, a_samp_addr_b;
    logic [5:0] a_strb;

    // Instance B: COEFF_COUNT=64, CHANNELS=3, SYMMETRIC=1, PIPE_LAT=0
    logic       b_in_valid, b_in_ready, b_dp_clr, b_ld_in, b_mac_en, b_ld_out;
    logic       b_out_valid, b_out_ready;
    logic [1:0] b_in_ch, b_out_ch;
    logic [5:0] b_coeff_addr;
    logic [7:0] b_samp_addr_a, b_samp_addr_b;
    logic [5:0] b_strb;

    assign a_strb = {a_dp_clr, a_ld_in, a_mac_en, a_ld_out, a_out_valid, a_in_ready};
    assign b_strb = {b_dp_clr, b_ld_in, b_mac_en, b_ld_out, b_out_valid, b_in_ready};

    // Bench-side write-pointer model for instance A
    int unsigned ptr_a [4];

    fir_mc_ctrl #(
        .COEFF_COUNT (64),
        .CHANNELS    (4),
        .SYMMETRIC   (0),
        .PIPE_LAT    (2)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (a_in_valid),
        .in_ch       (a_in_ch),
        .in_ready    (a_in_ready),
        .dp_clr      (a_dp_clr),
        .ld_in       (a_ld_in),
        .mac_en      (a_mac_en),
        .ld_out      (a_ld_out),
        .coeff_addr  (a_coeff_addr),
        .samp_addr_a (a_samp_addr_a),
        .samp_addr_b (a_samp_addr_b),
        .out_valid   (a_out_valid),
        .out_ready   (a_out_ready),
        .out_ch      (a_out_ch)
    );

    fir_mc_ctrl #(
        .COEFF_COUNT (64),
        .CHANNELS    (3),
        .SYMMETRIC   (1),
        .PIPE_LAT    (0)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (b_in_valid),
        .in_ch       (b_in_ch),
        .in_ready    (b_in_ready),
        .dp_clr      (b_dp_clr),
        .ld_in       (b_ld_in),
        .mac_en      (b_mac_en),
        .ld_out      (b_ld_out),
        .coeff_addr  (b_coeff_addr),
        .samp_addr_a (b_samp_addr_a),
        .samp_addr_b (b_samp_addr_b),
        .out_valid   (b_out_valid),
        .out_ready   (b_out_ready),
        .out_ch      (b_out_ch)
    );

    // Advance one clock; outputs are then observed 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full A transaction with out_ready high; returns the LOAD-cycle view.
    task automatic a_sample(input logic [1:0] ch, output logic [7:0] la, output logic ld);
        a_in_valid = 1'b1;
        a_in_ch    = ch;
        tick();
        la         = a_samp_addr_a;
        ld         = a_ld_in;
        a_in_valid = 1'b0;
        repeat (69) tick();
    endtask

    // One full B transaction with out_ready high.
    task automatic b_sample(input logic [1:0] ch);
        b_in_valid = 1'b1;
        b_in_ch    = ch;
        tick();
        b_in_valid = 1'b0;
        repeat (35) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vec++;
        if (a_strb !== 6'b000001) begin
            errs++; $display("FAIL reset_a_strobes: got %b expected %b", a_strb, 6'b000001);
        end
        vec++;
        if ({a_coeff_addr, a_samp_addr_a, a_samp_addr_b, a_out_ch} !== 24'h0) begin
            errs++; $display("FAIL reset_a_addr: got k=%0d a=%h b=%h ch=%0d expected all 0",
                             a_coeff_addr, a_samp_addr_a, a_samp_addr_b, a_out_ch);
        end
        vec++;
        if (b_strb !== 6'b000001) begin
            errs++; $display("FAIL reset_b_strobes: got %b expected %b", b_strb, 6'b000001);
        end
        vec++;
        if ({b_coeff_addr, b_samp_addr_a, b_samp_addr_b, b_out_ch} !== 24'h0) begin
            errs++; $display("FAIL reset_b_addr: got k=%0d a=%h b=%h ch=%0d expected all 0",
                             b_coeff_addr, b_samp_addr_a, b_samp_addr_b, b_out_ch);
        end
        rst = 1'b0;
        tick();
        vec++;
        if (a_strb !== 6'b000001) begin
            errs++; $display("FAIL reset_release_idle: got %b expected %b", a_strb, 6'b000001);
        end
    endtask

    task automatic test_latency();
        logic [5:0] exp_s;
        logic [5:0] e6;
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_ch     = 2'd0;
        for (int c = 1; c <= 70; c++) begin
            tick();
            if (c == 1) a_in_valid = 1'b0;
            exp_s = {c == 1, c == 1, (c >= 2) && (c <= 65), c == 68, c == 69, c == 70};
            vec++;
            if (a_strb !== exp_s) begin
                errs++; $display("FAIL latency_strobes t+%0d: got %b expected %b", c, a_strb, exp_s);
            end
            if (c == 1) begin
                vec++;
                if (a_samp_addr_a !== {2'd0, 6'(ptr_a[0])}) begin
                    errs++; $display("FAIL latency_load_addr: got %h expected %h", a_samp_addr_a, {2'd0, 6'(ptr_a[0])});
                end
            end
            if (c >= 2 && c <= 65) begin
                e6 = 6'(ptr_a[0] - 32'(c - 2));
                vec++;
                if ({a_coeff_addr, a_samp_addr_a, a_samp_addr_b} !== {6'(c - 2), 2'd0, e6, 8'h00}) begin
                    errs++; $display("FAIL latency_mac_addr t+%0d: got k=%0d a=%h b=%h expected k=%0d a=%h b=00",
                                     c, a_coeff_addr, a_samp_addr_a, a_samp_addr_b, c - 2, {2'd0, e6});
                end
            end
            if (c == 69) begin
                vec++;
                if (a_out_ch !== 2'd0) begin
                    errs++; $display("FAIL latency_out_ch: got %0d expected 0", a_out_ch);
                end
            end
        end
        ptr_a[0] = (ptr_a[0] + 1) % 64;
    endtask

    task automatic test_wrap();
        logic [7:0] la;
        logic       ld;
        for (int i = 0; i < 65; i++) begin
            a_sample(2'd1, la, ld);
            vec++;
            if (ld !== 1'b1 || la !== {2'd1, 6'(ptr_a[1])}) begin
                errs++; $display("FAIL wrap_load sample %0d: got ld=%b a=%h expected ld=1 a=%h",
                                 i, ld, la, {2'd1, 6'(ptr_a[1])});
            end
            ptr_a[1] = (ptr_a[1] + 1) % 64;
        end
        vec++;
        if (a_in_ready !== 1'b1) begin
            errs++; $display("FAIL wrap_back_to_idle: in_ready got %b expected 1", a_in_ready);
        end
        a_sample(2'd0, la, ld);
        vec++;
        if (la !== {2'd0, 6'(ptr_a[0])}) begin
            errs++; $display("FAIL wrap_ch0_untouched: got %h expected %h", la, {2'd0, 6'(ptr_a[0])});
        end
        ptr_a[0] = (ptr_a[0] + 1) % 64;
    endtask

    task automatic test_backpressure();
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_ch     = 2'd3;
        tick();
        a_in_valid = 1'b0;
        repeat (68) tick();
        vec++;
        if (a_strb !== 6'b000010 || a_out_ch !== 2'd3) begin
            errs++; $display("FAIL bp_out_entry: got strb=%b ch=%0d expected strb=000010 ch=3", a_strb, a_out_ch);
        end
        a_in_valid = 1'b1;
        a_in_ch    = 2'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            vec++;
            if (a_strb !== 6'b000010 || a_out_ch !== 2'd3) begin
                errs++; $display("FAIL bp_hold cycle %0d: got strb=%b ch=%0d expected strb=000010 ch=3",
                                 i, a_strb, a_out_ch);
            end
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        tick();
        vec++;
        if (a_strb !== 6'b000001) begin
            errs++; $display("FAIL bp_release_idle: got %b expected %b", a_strb, 6'b000001);
        end
        tick();
        vec++;
        if (a_strb !== 6'b000001) begin
            errs++; $display("FAIL bp_stay_idle: got %b expected %b", a_strb, 6'b000001);
        end
        ptr_a[3] = (ptr_a[3] + 1) % 64;
    endtask

    task automatic test_reset_mid();
        logic [7:0] la;
        logic       ld;
        a_in_valid = 1'b1;
        a_in_ch    = 2'd2;
        tick();
        a_in_valid = 1'b0;
        repeat (10) tick();
        vec++;
        if (a_mac_en !== 1'b1) begin
            errs++; $display("FAIL rstmid_in_mac: mac_en got %b expected 1", a_mac_en);
        end
        rst = 1'b1;
        tick();
        vec++;
        if (a_strb !== 6'b000001) begin
            errs++; $display("FAIL rstmid_strobes: got %b expected %b", a_strb, 6'b000001);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ptr_a[i] = 0;
        a_sample(2'd2, la, ld);
        vec++;
        if (la !== {2'd2, 6'(ptr_a[2])}) begin
            errs++; $display("FAIL rstmid_ch2_addr: got %h expected %h", la, {2'd2, 6'(ptr_a[2])});
        end
        ptr_a[2] = (ptr_a[2] + 1) % 64;
        a_sample(2'd1, la, ld);
        vec++;
        if (la !== {2'd1, 6'(ptr_a[1])}) begin
            errs++; $display("FAIL rstmid_ch1_addr: got %h expected %h", la, {2'd1, 6'(ptr_a[1])});
        end
        ptr_a[1] = (ptr_a[1] + 1) % 64;
    endtask

    task automatic test_sym_nodrain();
        int nmac   = 0;
        int last_m = 0;
        int ld_c   = 0;
        b_out_ready = 1'b1;
        // channel 3 does not exist on B: sample must be dropped
        b_in_valid = 1'b1;
        b_in_ch    = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (b_strb !== 6'b000001) begin
                errs++; $display("FAIL drop_bad_ch cycle %0d: got %b expected %b", i, b_strb, 6'b000001);
            end
        end
        b_in_valid = 1'b0;
        for (int i = 0; i < 5; i++) b_sample(2'd2);
        b_in_valid = 1'b1;
        b_in_ch    = 2'd2;
        for (int c = 1; c <= 36; c++) begin
            tick();
            if (c == 1) begin
                b_in_valid = 1'b0;
                vec++;
                if (b_ld_in !== 1'b1 || b_samp_addr_a !== 8'h85) begin
                    errs++; $display("FAIL sym_load: got ld=%b a=%h expected ld=1 a=85", b_ld_in, b_samp_addr_a);
                end
            end
            if (b_mac_en === 1'b1) begin
                nmac++;
                last_m = c;
            end
            if (b_ld_out === 1'b1) ld_c = c;
            if (c == 2) begin
                vec++;
                if ({b_coeff_addr, b_samp_addr_a, b_samp_addr_b} !== {6'd0, 8'h85, 8'h86}) begin
                    errs++; $display("FAIL sym_k0: got k=%0d a=%h b=%h expected k=0 a=85 b=86",
                                     b_coeff_addr, b_samp_addr_a, b_samp_addr_b);
                end
            end
            if (c == 33) begin
                vec++;
                if ({b_coeff_addr, b_samp_addr_a, b_samp_addr_b} !== {6'd31, 8'ha6, 8'ha5}) begin
                    errs++; $display("FAIL sym_k31: got k=%0d a=%h b=%h expected k=31 a=a6 b=a5",
                                     b_coeff_addr, b_samp_addr_a, b_samp_addr_b);
                end
            end
            if (c == 35) begin
                vec++;
                if (b_out_valid !== 1'b1 || b_out_ch !== 2'd2) begin
                    errs++; $display("FAIL sym_out: got valid=%b ch=%0d expected valid=1 ch=2", b_out_valid, b_out_ch);
                end
            end
        end
        vec++;
        if (nmac != 32) begin
            errs++; $display("FAIL sym_mac_count: got %0d expected 32", nmac);
        end
        vec++;
        if (last_m != 33 || ld_c != 34) begin
            errs++; $display("FAIL nodrain_ld_out: got last_mac=t+%0d ld_out=t+%0d expected t+33 t+34", last_m, ld_c);
        end
        vec++;
        if (b_in_ready !== 1'b1) begin
            errs++; $display("FAIL sym_back_to_idle: in_ready got %b expected 1", b_in_ready);
        end
    endtask

    initial begin
        rst         = 1'b1;
        a_in_valid  = 1'b0;
        a_in_ch     = '0;
        a_out_ready = 1'b0;
        b_in_valid  = 1'b0;
        b_in_ch     = '0;
        b_out_ready = 1'b0;
        for (int i = 0; i < 4; i++) ptr_a[i] = 0;
        test_reset();
        test_latency();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_sym_nodrain();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
